// File: rtl/fp_normalizer.sv
// Post-normalisation stage: shifts a raw add/sub result left until the leading one
// reaches bit 23, then presents a packed single-precision value through a valid/ready handshake.
//
//   state | meaning
//   IDLE  | waiting for a raw result; IN_READY high
//   NORM  | shifting left up to STEP positions per cycle
//   HOLD  | result presented; waiting for OUT_READY
module fp_normalizer #(
    parameter int STEP = 4
) (
    input  logic        FPUCLK,
    input  logic        FPURST,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic        IN_SIGN,
    input  logic [7:0]  IN_EXP,
    input  logic [23:0] IN_MANT,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic [31:0] OUT,
    output logic        OUT_ZERO,
    output logic        OUT_UF,
    output logic        BUSY
);

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        HOLD
    } state_t;

    localparam logic [4:0] STEP_W = 5'(STEP);

    state_t      state, state_nxt;
    logic        sign_q, sign_nxt;
    logic [7:0]  exp_q, exp_nxt;
    logic [23:0] mant_q, mant_nxt;
    logic [31:0] out_q, out_nxt;
    logic        zero_q, zero_nxt;
    logic        uf_q, uf_nxt;

    logic [4:0]  lz;
    logic [4:0]  k;
    logic [7:0]  exp_dec;
    logic [23:0] mant_shl;

    // Highest set bit wins; an all-zero input never reaches NORM.
    function automatic logic [4:0] lead_zeros(input logic [23:0] m);
        logic [4:0] n;
        n = 5'd24;
        for (int i = 0; i < 24; i++) begin
            if (m[i]) n = 5'(23 - i);
        end
        return n;
    endfunction

    always_comb begin
        lz       = lead_zeros(mant_q);
        k        = (lz > STEP_W) ? STEP_W : lz;
        exp_dec  = exp_q - {3'b000, k};
        mant_shl = mant_q << k;
    end

    always_comb begin
        state_nxt = state;
        sign_nxt  = sign_q;
        exp_nxt   = exp_q;
        mant_nxt  = mant_q;
        out_nxt   = out_q;
        zero_nxt  = zero_q;
        uf_nxt    = uf_q;
        case (state)
            IDLE: begin
                if (IN_VALID) begin
                    sign_nxt = IN_SIGN;
                    exp_nxt  = IN_EXP;
                    mant_nxt = IN_MANT;
                    zero_nxt = 1'b0;
                    uf_nxt   = 1'b0;
                    if (IN_EXP == 8'hFF) begin
                        out_nxt   = {IN_SIGN, IN_EXP, IN_MANT[22:0]};
                        state_nxt = HOLD;
                    end else if (IN_MANT == 24'd0) begin
                        out_nxt   = {IN_SIGN, 31'd0};
                        zero_nxt  = 1'b1;
                        state_nxt = HOLD;
                    end else if (IN_MANT[23]) begin
                        out_nxt   = {IN_SIGN, IN_EXP, IN_MANT[22:0]};
                        state_nxt = HOLD;
                    end else begin
                        state_nxt = NORM;
                    end
                end
            end
            NORM: begin
                // Exponent would reach zero or below: flush rather than produce a denormal.
                if (exp_q <= {3'b000, k}) begin
                    out_nxt   = {sign_q, 31'd0};
                    zero_nxt  = 1'b1;
                    uf_nxt    = 1'b1;
                    state_nxt = HOLD;
                end else begin
                    exp_nxt  = exp_dec;
                    mant_nxt = mant_shl;
                    if (lz <= STEP_W) begin
                        out_nxt   = {sign_q, exp_dec, mant_shl[22:0]};
                        state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                if (OUT_READY) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge FPUCLK) begin
        if (FPURST) begin
            state  <= IDLE;
            sign_q <= 1'b0;
            exp_q  <= 8'd0;
            mant_q <= 24'd0;
            out_q  <= 32'd0;
            zero_q <= 1'b0;
            uf_q   <= 1'b0;
        end else begin
            state  <= state_nxt;
            sign_q <= sign_nxt;
            exp_q  <= exp_nxt;
            mant_q <= mant_nxt;
            out_q  <= out_nxt;
            zero_q <= zero_nxt;
            uf_q   <= uf_nxt;
        end
    end

    assign IN_READY  = (state == IDLE) & ~FPURST;
    assign OUT_VALID = (state == HOLD);
    assign BUSY      = (state != IDLE);
    assign OUT       = out_q;
    assign OUT_ZERO  = zero_q;
    assign OUT_UF    = uf_q;

endmodule
